// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: region codes, MMIO
// offsets, store encodings, the EX/WB register layout and store helpers.
package mem_stage_pkg;

  // Address region codes, decoded from address bits [31:28]
  localparam logic [3:0] REGION_DMEM     = 4'b0001;
  localparam logic [3:0] REGION_IMEM     = 4'b0010;
  localparam logic [3:0] REGION_DMEM_ALT = 4'b0011;
  localparam logic [3:0] REGION_BIOS     = 4'b0100;
  localparam logic [3:0] REGION_MMIO     = 4'b1000;

  // MMIO register offsets (address bits [7:0])
  localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
  localparam logic [7:0] MMIO_UART_RX   = 8'h04;
  localparam logic [7:0] MMIO_UART_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
  localparam logic [7:0] MMIO_CNT_CLEAR = 8'h18;

  // WB source select value that marks an instruction as a memory load
  localparam logic [1:0] WB_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] pc_plus;
    logic [4:0]  wb_addr;
    logic [1:0]  control_wr_mux;
    logic [2:0]  control_load;
    logic        reg_we;
  } wb_reg_t;

  // Byte enables for a store: SB picks one lane, SH one half, SW all four
  function automatic logic [3:0] store_mask(store_e st, logic [1:0] byte_off);
    logic [3:0] mask;
    mask = 4'b0000;
    case (st)
      ST_SB:   mask = 4'b0001 << byte_off;
      ST_SH:   mask = byte_off[1] ? 4'b1100 : 4'b0011;
      ST_SW:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Store data replicated across lanes so the byte mask alone selects it
  function automatic logic [31:0] store_data(store_e st, logic [31:0] data);
    logic [31:0] rep;
    rep = data;
    case (st)
      ST_SB:   rep = {4{data[7:0]}};
      ST_SH:   rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_stage_mmio_counters.sv
// Cycle and retired-instruction counters behind the MMIO window.
// Present only when MMIO_COUNTERS_EN is defined.
`ifdef MMIO_COUNTERS_EN
module mem_stage_mmio_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             clear,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  logic inst_inc;

  // An instruction retires only if it is real and actually leaves EX
  assign inst_inc = inst_valid && !stall && !flush;

  // Counter update: reset and clear both zero, clear beats increment
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (inst_inc) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: drives DMEM/IMEM/BIOS ports,
// decodes the MMIO window (UART, counters) and holds the EX/WB register.
// Build option: define MMIO_COUNTERS_EN to include the cycle/instruction
// counters at MMIO 0x10/0x14 and the clear at 0x18; otherwise they read 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW = 14,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        alu_result_i,
  input  logic [31:0]        rs2_data_i,
  input  logic [1:0]         control_store_i,
  input  logic [2:0]         control_load_i,
  input  logic [1:0]         control_wr_mux_i,
  input  logic [4:0]         wb_addr_i,
  input  logic               reg_we_i,
  input  logic [31:0]        pc_plus_i,
  input  logic               inst_valid_i,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [31:0]        dmem_din_o,
  output logic [3:0]         dmem_we_o,
  output logic [DMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_din_o,
  output logic [3:0]         imem_we_o,
  output logic [11:0]        bios_addrb_o,
  output logic [7:0]         uart_tx_data_o,
  output logic               uart_tx_valid_o,
  input  logic               uart_tx_ready_i,
  input  logic [7:0]         uart_rx_data_i,
  input  logic               uart_rx_valid_i,
  output logic               uart_rx_ready_o,
  output logic [31:0]        alu_result_o,
  output logic [31:0]        pc_plus_o,
  output logic [4:0]         wb_addr_o,
  output logic [1:0]         control_wr_mux_o,
  output logic [2:0]         control_load_o,
  output logic               reg_we_o,
  output logic [31:0]        io_rdata_o
);

  logic [3:0]       region;
  logic [7:0]       offset;
  store_e           store_type;
  logic             is_store;
  logic             is_load;
  logic             commit;
  logic             in_dmem;
  logic             in_imem;
  logic             in_mmio;
  logic [3:0]       byte_mask;
  logic [31:0]      wr_data;
  logic [31:0]      io_rdata_next;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] inst_count;
  wb_reg_t          wb_q;
  logic             unused_bits;

  assign region     = alu_result_i[31:28];
  assign offset     = alu_result_i[7:0];
  assign store_type = store_e'(control_store_i);
  assign is_store   = (store_type != ST_NONE);
  assign is_load    = !is_store && reg_we_i && (control_wr_mux_i == WB_SRC_MEM);

  // Side effects happen only when the instruction really leaves EX
  assign commit  = !rst && !stall_i && !flush_i;
  assign in_dmem = (region == REGION_DMEM) || (region == REGION_DMEM_ALT);
  assign in_imem = (region == REGION_IMEM);
  assign in_mmio = (region == REGION_MMIO);

  assign byte_mask = store_mask(store_type, alu_result_i[1:0]);
  assign wr_data   = store_data(store_type, rs2_data_i);

  // Memory ports: word addresses are straight slices of the EX address
  assign dmem_addr_o  = alu_result_i[DMEM_AW+1:2];
  assign imem_addr_o  = alu_result_i[DMEM_AW+1:2];
  assign bios_addrb_o = alu_result_i[13:2];
  assign dmem_din_o   = wr_data;
  assign imem_din_o   = wr_data;
  assign dmem_we_o    = (commit && in_dmem) ? byte_mask : 4'b0000;
  assign imem_we_o    = (commit && in_imem) ? byte_mask : 4'b0000;

  // UART handshake: a byte moves only in a cycle where valid and ready are
  // both high; there is no buffering on either side. TX valid is raised only
  // when the transmitter is already ready (software polls status first), so
  // a store while not ready is dropped. RX ready pulses for one cycle on a
  // load of the RX register, and the RX byte is captured in that same cycle.
  assign uart_tx_data_o  = rs2_data_i[7:0];
  assign uart_tx_valid_o = commit && in_mmio && is_store &&
                           (offset == MMIO_UART_TX) && uart_tx_ready_i;
  assign uart_rx_ready_o = commit && in_mmio && is_load &&
                           (offset == MMIO_UART_RX);

`ifdef MMIO_COUNTERS_EN
  logic counter_clear;

  assign counter_clear = commit && in_mmio && is_store &&
                         (offset == MMIO_CNT_CLEAR);

  mem_stage_mmio_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid_i),
    .stall       (stall_i),
    .flush       (flush_i),
    .clear       (counter_clear),
    .cycle_count (cycle_count),
    .inst_count  (inst_count)
  );
`else
  assign cycle_count = '0;
  assign inst_count  = '0;
`endif

  // Address bits above the word index and the counter qualifier are not
  // needed in every build
  assign unused_bits = ^{alu_result_i, inst_valid_i, uart_rx_valid_i};

  // MMIO read mux; unmapped offsets and non-MMIO accesses read 0
  always_comb begin
    io_rdata_next = 32'h0;
    if (in_mmio && is_load) begin
      case (offset)
        MMIO_UART_CTRL: io_rdata_next = {30'h0, uart_rx_valid_i, uart_tx_ready_i};
        MMIO_UART_RX:   io_rdata_next = {24'h0, uart_rx_data_i};
        MMIO_CYCLE_CNT: io_rdata_next = 32'(cycle_count);
        MMIO_INST_CNT:  io_rdata_next = 32'(inst_count);
        default:        io_rdata_next = 32'h0;
      endcase
    end
  end

  // EX/WB register: stall holds, flush loads a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      io_rdata_o <= '0;
    end else if (!stall_i) begin
      if (flush_i) begin
        wb_q       <= '0;
        io_rdata_o <= '0;
      end else begin
        wb_q.alu_result     <= alu_result_i;
        wb_q.pc_plus        <= pc_plus_i;
        wb_q.wb_addr        <= wb_addr_i;
        wb_q.control_wr_mux <= control_wr_mux_i;
        wb_q.control_load   <= control_load_i;
        wb_q.reg_we         <= reg_we_i;
        io_rdata_o          <= io_rdata_next;
      end
    end
  end

  assign alu_result_o     = wb_q.alu_result;
  assign pc_plus_o        = wb_q.pc_plus;
  assign wb_addr_o        = wb_q.wb_addr;
  assign control_wr_mux_o = wb_q.control_wr_mux;
  assign control_load_o   = wb_q.control_load;
  assign reg_we_o         = wb_q.reg_we;

endmodule
